// File: rtl/fetch_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fetch_seq_if                                              |
// | Purpose  : Bundles the byte-wide instruction-memory read channel and |
// |            the valid/ready instruction channel toward decode.        |
// | Ports    : mem_req/mem_addr/mem_ack/mem_rdata  - memory read channel |
// |            out_valid/out_ready + icode, ifun, rA, rB, valC, valP,    |
// |            pc_out, stat                     - fetched instruction    |
// | Modports : master - fetch sequencer side                             |
// |            slave  - memory model / decode side                       |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface fetch_seq_if;
   logic        mem_req;
   logic [63:0] mem_addr;
   logic        mem_ack;
   logic [7:0]  mem_rdata;

   logic        out_valid;
   logic        out_ready;
   logic [3:0]  icode;
   logic [3:0]  ifun;
   logic [3:0]  rA;
   logic [3:0]  rB;
   logic [63:0] valC;
   logic [63:0] valP;
   logic [63:0] pc_out;
   logic [1:0]  stat;

   modport master (
      output mem_req, mem_addr,
      input  mem_ack, mem_rdata,
      output out_valid, icode, ifun, rA, rB, valC, valP, pc_out, stat,
      input  out_ready
   );

   modport slave (
      input  mem_req, mem_addr,
      output mem_ack, mem_rdata,
      input  out_valid, icode, ifun, rA, rB, valC, valP, pc_out, stat,
      output out_ready
   );
endinterface
`default_nettype wire

// File: rtl/fetch_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fetch_seq                                                 |
// | Purpose  : Multi-cycle Y86-64 instruction fetch. Owns the PC, reads  |
// |            one byte per memory transaction, sizes the instruction    |
// |            from byte 0, and presents the split fields to decode.     |
// | Ports    : clk, rst_n (async, active low)                            |
// |            bus         - fetch_seq_if.master (memory + decode side)  |
// |            redirect / redirect_pc - next-PC override at acceptance   |
// |            restart / restart_pc   - leave HALT and resume at a PC    |
// |            halted      - high while in HALT                          |
// | Option   : FETCH_ADR_CHECK_EN - bound-check each address against     |
// |            MEM_BYTES before requesting it (one extra cycle per byte) |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module fetch_seq #(
   parameter int MEM_BYTES = 2048
) (
   input  wire logic        clk,
   input  wire logic        rst_n,
   fetch_seq_if.master      bus,
   input  wire logic        redirect,
   input  wire logic [63:0] redirect_pc,
   input  wire logic        restart,
   input  wire logic [63:0] restart_pc,
   output logic             halted
);

   localparam logic [1:0] STAT_AOK = 2'b00;
   localparam logic [1:0] STAT_HLT = 2'b01;
   localparam logic [1:0] STAT_ADR = 2'b10;
   localparam logic [1:0] STAT_INS = 2'b11;

   typedef enum logic [1:0] {FETCH0, FETCHN, VALID, HALT} state_t;

   // Instruction length in bytes; invalid icodes count as one byte.
   function automatic logic [3:0] instr_len(input logic [3:0] ic);
      case (ic)
         4'h0, 4'h1, 4'h9:       instr_len = 4'd1;
         4'h2, 4'h6, 4'hA, 4'hB: instr_len = 4'd2;
         4'h7, 4'h8:             instr_len = 4'd9;
         4'h3, 4'h4, 4'h5:       instr_len = 4'd10;
         default:                instr_len = 4'd1;
      endcase
   endfunction

   function automatic logic has_regs(input logic [3:0] ic);
      case (ic)
         4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: has_regs = 1'b1;
         default:                                   has_regs = 1'b0;
      endcase
   endfunction

   state_t      state, state_n;
   logic [63:0] pc;
   logic [3:0]  k;                 // byte index within the current instruction
   logic [7:0]  ibuf [10];         // bytes collected so far
   logic [7:0]  cur  [10];         // ibuf with the byte arriving this cycle merged in

   logic [3:0]  icode_q, ifun_q, ra_q, rb_q;
   logic [63:0] valc_q, valp_q, pc_out_q;
   logic [1:0]  stat_q;

   logic        fetching, go, cap, accept, addr_oob, adr_fault;
   logic        last_byte, enter_valid, cur_inv;
   logic [63:0] addr, cur_valc;
   logic [3:0]  cur_ic, cur_len;

   assign fetching = (state == FETCH0) || (state == FETCHN);
   assign addr     = pc + {60'd0, k};
   assign addr_oob = (addr >= 64'(MEM_BYTES));

`ifdef FETCH_ADR_CHECK_EN
   // chk_ok marks that the current address already passed the bound
   // compare; the request goes out only in the cycle after the compare.
   logic chk_ok;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         chk_ok <= 1'b0;
      else if (cap || !fetching)
         chk_ok <= 1'b0;
      else if (!chk_ok && !addr_oob)
         chk_ok <= 1'b1;
   end

   assign go        = chk_ok;
   assign adr_fault = fetching && !chk_ok && addr_oob;
`else
   // The bound compare stays elaborated so both builds share one
   // datapath; without the check it can never raise a fault.
   assign go        = 1'b1;
   assign adr_fault = addr_oob & 1'b0;
`endif

   // Gating with rst_n drops the request the moment reset asserts.
   assign bus.mem_req  = rst_n && fetching && go;
   assign bus.mem_addr = addr;
   assign cap          = bus.mem_req && bus.mem_ack;
   assign accept       = bus.out_valid && bus.out_ready;

   // In FETCH0 stale bytes from the previous instruction read as zero, so a
   // short or aborted instruction never inherits old constant bytes.
   always_comb begin
      for (int i = 0; i < 10; i++) begin
         cur[i] = (state == FETCH0) ? 8'h00 : ibuf[i];
         if (cap && (k == 4'(i)))
            cur[i] = bus.mem_rdata;
      end
   end

   assign cur_ic    = cur[0][7:4];
   assign cur_len   = instr_len(cur_ic);
   assign cur_inv   = (cur_ic > 4'hB);
   assign last_byte = (k == (cur_len - 4'd1));

   always_comb begin
      case (cur_ic)
         4'h7, 4'h8:       cur_valc = {cur[8], cur[7], cur[6], cur[5],
                                       cur[4], cur[3], cur[2], cur[1]};
         4'h3, 4'h4, 4'h5: cur_valc = {cur[9], cur[8], cur[7], cur[6],
                                       cur[5], cur[4], cur[3], cur[2]};
         default:          cur_valc = 64'd0;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= FETCH0;
      else
         state <= state_n;
   end

   // Next-state logic
   always_comb begin
      state_n = state;
      case (state)
         FETCH0, FETCHN: begin
            if (adr_fault)
               state_n = VALID;
            else if (cap)
               state_n = last_byte ? VALID : FETCHN;
         end
         VALID: begin
            if (accept)
               state_n = (stat_q == STAT_AOK) ? FETCH0 : HALT;
         end
         HALT: begin
            if (restart)
               state_n = FETCH0;
         end
         default: state_n = FETCH0;
      endcase
   end

   assign enter_valid = fetching && (state_n == VALID);

   // Datapath: PC, byte collection and the registered output fields.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc       <= 64'd0;
         k        <= 4'd0;
         for (int i = 0; i < 10; i++)
            ibuf[i] <= 8'h00;
         icode_q  <= 4'h0;
         ifun_q   <= 4'h0;
         ra_q     <= 4'hF;
         rb_q     <= 4'hF;
         valc_q   <= 64'd0;
         valp_q   <= 64'd0;
         pc_out_q <= 64'd0;
         stat_q   <= STAT_AOK;
      end else begin
         if (cap)
            for (int i = 0; i < 10; i++)
               ibuf[i] <= cur[i];

         if (enter_valid)
            k <= 4'd0;
         else if (cap)
            k <= k + 4'd1;

         if (enter_valid) begin
            icode_q  <= cur_ic;
            ifun_q   <= cur[0][3:0];
            ra_q     <= has_regs(cur_ic) ? cur[1][7:4] : 4'hF;
            rb_q     <= has_regs(cur_ic) ? cur[1][3:0] : 4'hF;
            valc_q   <= cur_valc;
            valp_q   <= pc + {60'd0, cur_len};
            pc_out_q <= pc;
            if (adr_fault)
               stat_q <= STAT_ADR;
            else if (cur_inv)
               stat_q <= STAT_INS;
            else if (cur_ic == 4'h0)
               stat_q <= STAT_HLT;
            else
               stat_q <= STAT_AOK;
         end

         if ((state == VALID) && accept && (stat_q == STAT_AOK))
            pc <= redirect ? redirect_pc : valp_q;

         if ((state == HALT) && restart) begin
            pc     <= restart_pc;
            stat_q <= STAT_AOK;
         end
      end
   end

   assign bus.out_valid = (state == VALID);
   assign bus.icode     = icode_q;
   assign bus.ifun      = ifun_q;
   assign bus.rA        = ra_q;
   assign bus.rB        = rb_q;
   assign bus.valC      = valc_q;
   assign bus.valP      = valp_q;
   assign bus.pc_out    = pc_out_q;
   assign bus.stat      = stat_q;
   assign halted        = (state == HALT);

endmodule
`default_nettype wire

// File: doc/fetch_seq.md
# fetch_seq

Multi-cycle instruction fetch sequencer for the Y86-64 SEQ core. It owns the PC register and reads one byte per transaction from a byte-wide instruction memory. From byte 0 it determines instruction length, collects the remaining bytes, and presents the split fields (icode, ifun, rA, rB, valC, valP) to decode through a valid/ready handshake. The next PC comes either from valP or from a redirect supplied by later stages.

## Interface
- MEM_BYTES, 2048: instruction memory size in bytes; the valid address range is 0..MEM_BYTES-1.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_req  out  1  byte read request; held until acknowledged.
- mem_addr  out  64  byte address; stable while mem_req=1.
- mem_ack  in  1  read complete; mem_rdata is valid in the same cycle.
- mem_rdata  in  8  read byte.
- out_valid  out  1  assembled instruction available.
- out_ready  in  1  decode accepts the instruction.
- icode, ifun  out  4 each  fields from byte 0 (high/low nibble).
- rA, rB  out  4 each  from byte 1 (high/low nibble); 4'hF when the instruction has no register byte.
- valC  out  64  little-endian constant; 0 when the instruction has no constant.
- valP  out  64  PC of the instruction plus its length.
- pc_out  out  64  PC of the presented instruction.
- stat  out  2  status: 00 AOK, 01 HLT, 10 ADR, 11 INS.
- redirect  in  1  sampled on acceptance; selects redirect_pc as the next PC.
- redirect_pc  in  64  next PC for jXX, call and ret.
- restart  in  1  single-cycle pulse; leaves HALT.
- restart_pc  in  64  PC to resume fetching from.
- halted  out  1  high while in the HALT state.

## Operation
- Instruction lengths by icode:
  - 0 (halt), 1 (nop), 9 (ret): 1 byte.
  - 2 (cmov), 6 (OPq), A (pushq), B (popq): 2 bytes, register byte only.
  - 7 (jXX), 8 (call): 9 bytes, valC in bytes 1..8.
  - 3 (irmovq), 4 (rmmovq), 5 (mrmovq): 10 bytes, register byte at 1, valC in bytes 2..9.
  - icode greater than B: invalid.
- States:
  - FETCH0: request pc. On ack, latch byte 0 and decode the length. Length 1 or invalid icode → VALID; otherwise → FETCHN.
  - FETCHN: request pc+k for k=1..len-1, incrementing k on each ack. After the final ack → VALID.
  - VALID: out_valid=1 and all outputs held stable. On out_valid&&out_ready:
    - stat AOK → pc ← redirect ? redirect_pc : valP, then → FETCH0.
    - stat not AOK → HALT.
  - HALT: halted=1 and no memory requests. A restart pulse sets pc ← restart_pc, clears stat and → FETCH0. restart in any other state is ignored.
- Status rules:
  - icode 0 → stat=HLT.
  - Invalid icode → stat=INS; no further bytes are fetched; rA=rB=F, valC=0, valP=pc+1.
- valP arithmetic is 64-bit modulo 2^64; no carry is reported.
- Reset drives mem_req=0, out_valid=0, pc=0, stat=AOK, halted=0, rA=rB=F, icode, ifun, valC, valP and pc_out to 0, and the state to FETCH0. Fetching of pc=0 starts on the first edge after release.
- Reset asserted mid-fetch aborts the fetch immediately. mem_req drops combinationally with rst_n, and any partial bytes are discarded.

## Timing
- mem_ack may arrive in the same cycle as mem_req (zero wait state) or any number of cycles later. Data is captured on the edge where mem_req&&mem_ack.
- At most one byte transfer per cycle.
- With zero-wait memory, an N-byte instruction takes N request cycles. out_valid rises in the cycle after the last ack.
- After acceptance, the FETCH0 request for the next PC is issued in the following cycle, giving a throughput of N+1 cycles per instruction.
- Without FETCH_ADR_CHECK_EN, the worst case is 11 cycles per instruction, for a 10-byte instruction.
- Outputs are registered. stat and the fields change only on entry to VALID, on reset, or on restart.

## Configuration
- FETCH_ADR_CHECK_EN defined:
  - Before each request, the target address is compared against MEM_BYTES.
  - If the address is at or above MEM_BYTES, no request is issued. The block goes to VALID with stat=ADR and the bytes collected so far, with missing bytes reading as 0. It enters HALT after acceptance.
  - The check costs one extra cycle per byte.
- FETCH_ADR_CHECK_EN undefined:
  - No bound check; every address is issued as-is and stat is never ADR.
  - Zero-wait timing is as given in Timing.

## Test plan
- Memory 30 F4 0A 00 00 00 00 00 00 00 at 0, zero-wait memory, out_ready=1 → icode=3, ifun=0, rA=F, rB=4, valC=10, valP=10, stat=AOK, out_valid rises 10 cycles after reset release.
- Memory 70 20 00 00 00 00 00 00 00 at 0, redirect=1, redirect_pc=32, with 10 00 at 32 → second fetch is at mem_addr=32, giving icode=1, valP=33.
- Memory 60 23 at 0 with 3-cycle ack latency and out_ready held low for 5 cycles → outputs stable throughout the wait; icode=6, rA=2, rB=3, valP=2; no new mem_req until acceptance.
- Byte 0 = C0 → stat=INS, only one memory request, valP=1, halted=1 after acceptance. Then restart_pc=0 pointing at 00 → stat=HLT, halted=1 again.
- rst_n pulsed low during byte 5 of an irmovq → mem_req=0 and out_valid=0 immediately; the fetch restarts at pc=0 after release.
- With FETCH_ADR_CHECK_EN, MEM_BYTES=2048 and pc=2045 holding irmovq → stat=ADR, exactly 3 requests issued (2045–2047), halted=1 after acceptance.
